// File: rtl/xmodem_crc_frame_checker_pkg.sv
// Shared constants and types for the XMODEM-CRC receive path.
// The TX-side generator uses the same constants.
package xmodem_crc_frame_checker_pkg;

   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam logic [15:0] CRC16_INIT = 16'h0000;
   localparam logic [7:0]  XM_SOH     = 8'h01;
   localparam logic [7:0]  XM_EOT     = 8'h04;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_BLK,
      ST_NBLK,
      ST_DATA,
      ST_CRC_HI,
      ST_CRC_LO
   } xm_state_e;

endpackage

// File: rtl/xmodem_crc_frame_checker_crc16_xmodem_step.sv
// One-byte CRC16-XMODEM update. Bits are processed MSB first with no reflection.
// The logic is purely combinational.
module crc16_xmodem_step
   import xmodem_crc_frame_checker_pkg::*;
(
   input  logic [15:0] crc_i,
   input  logic [7:0]  data_i,
   output logic [15:0] crc_o
);

   logic [15:0] c;
   logic        fb;

   always_comb begin
      c  = crc_i;
      fb = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         fb = c[15] ^ data_i[i];
         c  = {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
      end
      crc_o = c;
   end

endmodule

// File: rtl/xmodem_crc_frame_checker.sv
// Receive-side XMODEM-CRC block parser.
// Streams the payload, checks the header and the CRC residue, and detects timeouts and EOT.
module xmodem_crc_frame_checker
   import xmodem_crc_frame_checker_pkg::*;
#(
   parameter int PAYLOAD_LEN    = 128,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       CLK_I,
   input  logic       RST_I,
   input  logic       ABORT_I,
   input  logic       DATA_VALID_I,
   input  logic [7:0] DATA_I,
   output logic       PAYLOAD_VALID_O,
   output logic [7:0] PAYLOAD_O,
   output logic [9:0] PAYLOAD_IDX_O,
   output logic       FRAME_DONE_O,
   output logic       FRAME_OK_O,
   output logic       HDR_ERR_O,
   output logic       CRC_ERR_O,
   output logic       TIMEOUT_ERR_O,
   output logic [7:0] BLK_NUM_O,
   output logic       EOT_O
);

   localparam int IDX_W = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

   xm_state_e   state_q, state_d;
   logic [15:0] crc_q, crc_d, crc_nxt;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic [7:0]  blk_q, blk_d, nblk_q, nblk_d;
   logic        pv_q, pv_d, done_q, done_d, ok_q, ok_d;
   logic        hdr_q, hdr_d, crcerr_q, crcerr_d, toerr_q, toerr_d, eot_q, eot_d;
   logic [7:0]  pdata_q, pdata_d, blk_num_q, blk_num_d;
   logic [9:0]  pidx_q, pidx_d;
   logic        hdr_bad;

   crc16_xmodem_step u_step (
      .crc_i  (crc_q),
      .data_i (DATA_I),
      .crc_o  (crc_nxt)
   );

   assign hdr_bad = (blk_q ^ nblk_q) != 8'hFF;

   always_comb begin
      state_d   = state_q;
      crc_d     = crc_q;
      idx_d     = idx_q;
      to_cnt_d  = to_cnt_q;
      blk_d     = blk_q;
      nblk_d    = nblk_q;
      pv_d      = 1'b0;
      pdata_d   = pdata_q;
      pidx_d    = pidx_q;
      done_d    = 1'b0;
      ok_d      = 1'b0;
      hdr_d     = 1'b0;
      crcerr_d  = 1'b0;
      toerr_d   = 1'b0;
      eot_d     = 1'b0;
      blk_num_d = blk_num_q;
      // Priority: abort, then an accepted byte, then timeout expiry.
      if (ABORT_I) begin
         state_d  = ST_IDLE;
         idx_d    = '0;
         to_cnt_d = '0;
      end else if (DATA_VALID_I) begin
         to_cnt_d = '0;
         case (state_q)
            ST_IDLE: begin
               if (DATA_I == XM_SOH) begin
                  state_d = ST_BLK;
                  crc_d   = CRC16_INIT;
                  idx_d   = '0;
               end else if (DATA_I == XM_EOT) begin
                  eot_d = 1'b1;
               end
            end
            ST_BLK: begin
               blk_d   = DATA_I;
               state_d = ST_NBLK;
            end
            ST_NBLK: begin
               nblk_d  = DATA_I;
               state_d = ST_DATA;
            end
            ST_DATA: begin
               crc_d   = crc_nxt;
               pv_d    = 1'b1;
               pdata_d = DATA_I;
               pidx_d  = 10'(idx_q);
               if (idx_q == IDX_W'(PAYLOAD_LEN - 1)) begin
                  idx_d   = '0;
                  state_d = ST_CRC_HI;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
            ST_CRC_HI: begin
               crc_d   = crc_nxt;
               state_d = ST_CRC_LO;
            end
            ST_CRC_LO: begin
               crc_d     = crc_nxt;
               state_d   = ST_IDLE;
               done_d    = 1'b1;
               hdr_d     = hdr_bad;
               crcerr_d  = crc_nxt != 16'h0000;
               ok_d      = !hdr_bad && (crc_nxt == 16'h0000);
               blk_num_d = blk_q;
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (state_q != ST_IDLE) begin
         if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d  = ST_IDLE;
            idx_d    = '0;
            to_cnt_d = '0;
            done_d   = 1'b1;
            toerr_d  = 1'b1;
         end else begin
            to_cnt_d = to_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state_q   <= ST_IDLE;
         crc_q     <= CRC16_INIT;
         idx_q     <= '0;
         to_cnt_q  <= '0;
         blk_q     <= '0;
         nblk_q    <= '0;
         pv_q      <= 1'b0;
         pdata_q   <= '0;
         pidx_q    <= '0;
         done_q    <= 1'b0;
         ok_q      <= 1'b0;
         hdr_q     <= 1'b0;
         crcerr_q  <= 1'b0;
         toerr_q   <= 1'b0;
         eot_q     <= 1'b0;
         blk_num_q <= '0;
      end else begin
         state_q   <= state_d;
         crc_q     <= crc_d;
         idx_q     <= idx_d;
         to_cnt_q  <= to_cnt_d;
         blk_q     <= blk_d;
         nblk_q    <= nblk_d;
         pv_q      <= pv_d;
         pdata_q   <= pdata_d;
         pidx_q    <= pidx_d;
         done_q    <= done_d;
         ok_q      <= ok_d;
         hdr_q     <= hdr_d;
         crcerr_q  <= crcerr_d;
         toerr_q   <= toerr_d;
         eot_q     <= eot_d;
         blk_num_q <= blk_num_d;
      end
   end

   assign PAYLOAD_VALID_O = pv_q;
   assign PAYLOAD_O       = pdata_q;
   assign PAYLOAD_IDX_O   = pidx_q;
   assign FRAME_DONE_O    = done_q;
   assign FRAME_OK_O      = ok_q;
   assign HDR_ERR_O       = hdr_q;
   assign CRC_ERR_O       = crcerr_q;
   assign TIMEOUT_ERR_O   = toerr_q;
   assign BLK_NUM_O       = blk_num_q;
   assign EOT_O           = eot_q;

endmodule

// File: tb/tb_xmodem_crc_frame_checker.sv
// Directed bench for the XMODEM-CRC checker.
// Instance A uses a 128-byte payload, and instance B uses a 9-byte payload.
module tb_xmodem_crc_frame_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, abort, dv, sel;
   logic [7:0] din;
   logic       dv_a, dv_b;
   assign dv_a = dv & ~sel;
   assign dv_b = dv & sel;

   logic       pv_a, done_a, ok_a, hdr_a, crc_a, to_a, eot_a;
   logic [7:0] pd_a, bn_a;
   logic [9:0] pi_a;
   logic       pv_b, done_b, ok_b, hdr_b, crc_b, to_b, eot_b;
   logic [7:0] pd_b, bn_b;
   logic [9:0] pi_b;

   xmodem_crc_frame_checker #(.PAYLOAD_LEN(128), .TIMEOUT_CYCLES(16)) dut (
      .CLK_I(clk), .RST_I(rst), .ABORT_I(abort), .DATA_VALID_I(dv_a), .DATA_I(din),
      .PAYLOAD_VALID_O(pv_a), .PAYLOAD_O(pd_a), .PAYLOAD_IDX_O(pi_a),
      .FRAME_DONE_O(done_a), .FRAME_OK_O(ok_a), .HDR_ERR_O(hdr_a), .CRC_ERR_O(crc_a),
      .TIMEOUT_ERR_O(to_a), .BLK_NUM_O(bn_a), .EOT_O(eot_a));

   xmodem_crc_frame_checker #(.PAYLOAD_LEN(9), .TIMEOUT_CYCLES(16)) dut9 (
      .CLK_I(clk), .RST_I(rst), .ABORT_I(abort), .DATA_VALID_I(dv_b), .DATA_I(din),
      .PAYLOAD_VALID_O(pv_b), .PAYLOAD_O(pd_b), .PAYLOAD_IDX_O(pi_b),
      .FRAME_DONE_O(done_b), .FRAME_OK_O(ok_b), .HDR_ERR_O(hdr_b), .CRC_ERR_O(crc_b),
      .TIMEOUT_ERR_O(to_b), .BLK_NUM_O(bn_b), .EOT_O(eot_b));

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one byte for exactly one edge; return just after that edge.
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      din = b;
      dv  = 1'b1;
      @(posedge clk);
      #1;
      dv = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic zeros_a(input int n, input int start);
      for (int i = 0; i < n; i++) begin
         send(8'h00);
         chk("a_pv", pv_a, 1);
         chk("a_idx", pi_a, start + i);
         chk("a_pd", pd_a, 0);
      end
   endtask

   task automatic frame_a(input logic [7:0] blk, input logic [7:0] nblk);
      send(8'h01);
      send(blk);
      send(nblk);
      zeros_a(128, 0);
      send(8'h00);
      chk("a_done_early", done_a, 0);
      send(8'h00);
   endtask

   logic seen;

   initial begin
      rst = 1'b1; abort = 1'b0; dv = 1'b0; sel = 1'b0; din = 8'h00;
      idle(2);
      chk("rst_pv", pv_a, 0);
      chk("rst_pd", pd_a, 0);
      chk("rst_idx", pi_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_flags", {ok_a, hdr_a, crc_a, to_a, eot_a}, 0);
      chk("rst_bn", bn_a, 0);
      @(negedge clk);
      rst = 1'b0;

      // 1: zero-payload block
      frame_a(8'h01, 8'hFE);
      chk("t1_done", done_a, 1);
      chk("t1_ok", ok_a, 1);
      chk("t1_errs", {hdr_a, crc_a, to_a}, 0);
      chk("t1_bn", bn_a, 8'h01);
      idle(1);
      chk("t1_done_drop", done_a, 0);
      chk("t1_ok_drop", ok_a, 0);
      chk("t1_bn_held", bn_a, 8'h01);

      // 2: "123456789" on the 9-byte instance, CRC 0x31C3
      sel = 1'b1;
      for (int pass = 0; pass < 2; pass++) begin
         send(8'h01); send(8'h05); send(8'hFA);
         for (int i = 0; i < 9; i++) begin
            send(8'h31 + 8'(i));
            chk("b_pv", pv_b, 1);
            chk("b_idx", pi_b, i);
            chk("b_pd", pd_b, 8'h31 + i);
         end
         send(8'h31);
         send(pass == 0 ? 8'hC3 : 8'hC2);
         chk("t2_done", done_b, 1);
         chk("t2_ok", ok_b, pass == 0 ? 1 : 0);
         chk("t2_crc", crc_b, pass == 0 ? 0 : 1);
         chk("t2_hdr", hdr_b, 0);
         chk("t2_bn", bn_b, 8'h05);
      end
      chk("t2_a_quiet", done_a, 0);
      sel = 1'b0;

      // 3: header error, then an immediately following good block
      frame_a(8'h01, 8'hFD);
      chk("t3_done", done_a, 1);
      chk("t3_hdr", hdr_a, 1);
      chk("t3_crc", crc_a, 0);
      chk("t3_ok", ok_a, 0);
      chk("t3_bn", bn_a, 8'h01);
      frame_a(8'h02, 8'hFD);
      chk("t3b_ok", ok_a, 1);
      chk("t3b_hdr", hdr_a, 0);
      chk("t3b_bn", bn_a, 8'h02);

      // 4: timeout after 10 payload bytes
      send(8'h01); send(8'h03); send(8'hFC);
      zeros_a(10, 0);
      idle(15);
      chk("t4_no_to_yet", done_a, 0);
      idle(1);
      chk("t4_done", done_a, 1);
      chk("t4_to", to_a, 1);
      chk("t4_others", {ok_a, hdr_a, crc_a}, 0);
      chk("t4_bn_held", bn_a, 8'h02);
      idle(1);
      chk("t4_to_drop", to_a, 0);
      // byte lands on the expiry cycle: reception continues
      send(8'h01); send(8'h04); send(8'hFB);
      zeros_a(10, 0);
      idle(15);
      zeros_a(1, 10);
      chk("t4b_no_to", done_a, 0);
      zeros_a(117, 11);
      send(8'h00); send(8'h00);
      chk("t4b_done", done_a, 1);
      chk("t4b_ok", ok_a, 1);
      chk("t4b_bn", bn_a, 8'h04);

      // 5: junk and EOT in IDLE, then abort mid-DATA
      send(8'h55);
      chk("t5_junk", {pv_a, done_a, eot_a}, 0);
      send(8'h04);
      chk("t5_eot", eot_a, 1);
      idle(1);
      chk("t5_eot_drop", eot_a, 0);
      send(8'h01); send(8'h06); send(8'hF9);
      zeros_a(5, 0);
      @(negedge clk);
      abort = 1'b1; dv = 1'b1; din = 8'h00;
      @(posedge clk);
      #1;
      abort = 1'b0; dv = 1'b0;
      chk("t5_abort_drop", pv_a, 0);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         idle(1);
         seen = seen | done_a;
      end
      chk("t5_no_done", seen, 0);
      send(8'h04);
      chk("t5_eot_after_abort", eot_a, 1);

      // 6: async reset mid-block, then a fresh block
      send(8'h01); send(8'h07); send(8'hF8);
      zeros_a(3, 0);
      #1 rst = 1'b1;
      #1;
      chk("t6_pv", pv_a, 0);
      chk("t6_idx", pi_a, 0);
      chk("t6_bn", bn_a, 0);
      chk("t6_flags", {done_a, ok_a, hdr_a, crc_a, to_a, eot_a}, 0);
      @(negedge clk);
      rst = 1'b0;
      frame_a(8'h08, 8'hF7);
      chk("t6_done", done_a, 1);
      chk("t6_ok", ok_a, 1);
      chk("t6_bn_new", bn_a, 8'h08);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
